// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants for the pipeline hazard / forwarding unit.
package hazard_fwd_unit_pkg;

  localparam int unsigned ASIZE_DEF   = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  // EXE operand source select encoding
  localparam int unsigned FWD_W       = 2;
  localparam logic [FWD_W-1:0] FWD_RF   = 2'd0;
  localparam logic [FWD_W-1:0] FWD_EXDM = 2'd1;
  localparam logic [FWD_W-1:0] FWD_WB   = 2'd2;

  // Tag record layout: {v, wen, waddr, memread} in ID_EXE, {v, wen, waddr} further down
  localparam int unsigned TAG_CTRL_W  = 3;
  localparam int unsigned WTAG_CTRL_W = 2;

  function automatic int unsigned tag_w(input int unsigned asize);
    return asize + TAG_CTRL_W;
  endfunction

  function automatic int unsigned wtag_w(input int unsigned asize);
    return asize + WTAG_CTRL_W;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// Per-source producer match and youngest-first forward priority.
module hazard_fwd_unit_fwd_sel
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned ASIZE    = ASIZE_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             use_src,
  input  logic [ASIZE-1:0] raddr,
  input  logic             t1_v,
  input  logic             t1_wen,
  input  logic [ASIZE-1:0] t1_waddr,
  input  logic             t2_v,
  input  logic             t2_wen,
  input  logic [ASIZE-1:0] t2_waddr,
  input  logic             t3_v,
  input  logic             t3_wen,
  input  logic [ASIZE-1:0] t3_waddr,
  output logic [FWD_W-1:0] sel_c,
  output logic             t1_hit_c,
  output logic             byp_c
);

  // Register 0 never matches when it is hardwired
  function automatic logic tag_hit(input logic v, input logic wen,
                                   input logic [ASIZE-1:0] waddr,
                                   input logic [ASIZE-1:0] r);
    return v && wen && (waddr == r) && ((ZERO_REG == 0) || (r != '0));
  endfunction

  logic t2_hit_c;

  // Match each stage, then pick the youngest producer
  always_comb begin
    t1_hit_c = use_src && tag_hit(t1_v, t1_wen, t1_waddr, raddr);
    t2_hit_c = use_src && tag_hit(t2_v, t2_wen, t2_waddr, raddr);
    byp_c    = use_src && tag_hit(t3_v, t3_wen, t3_waddr, raddr);
    sel_c    = FWD_RF;
    if (t1_hit_c) begin
      sel_c = FWD_EXDM;
    end else if (t2_hit_c) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: destination scoreboard, forward selects, stall/flush control.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned ASIZE    = ASIZE_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_raddr1,
  input  logic [ASIZE-1:0] id_raddr2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_wen,
  input  logic [ASIZE-1:0] id_waddr,
  input  logic             id_memread,
  input  logic             exe_taken,
  output logic             pc_hold,
  output logic             flush_if,
  output logic             bubble_id,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             id_byp1,
  output logic             id_byp2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TAG_W  = tag_w(ASIZE);
  localparam int unsigned WTAG_W = wtag_w(ASIZE);

  typedef struct packed {
    logic             v;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic             memread;
  } tag_t;

  // The load flag only matters while the producer sits in ID_EXE
  typedef struct packed {
    logic             v;
    logic             wen;
    logic [ASIZE-1:0] waddr;
  } wtag_t;

  localparam tag_t             TAG_NONE  = tag_t'({TAG_W{1'b0}});
  localparam wtag_t            WTAG_NONE = wtag_t'({WTAG_W{1'b0}});
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  tag_t             t1;
  wtag_t            t2;
  wtag_t            t3;
  tag_t             id_tag;
  logic [FWD_W-1:0] sel_a_c;
  logic [FWD_W-1:0] sel_b_c;
  logic             hit1_c;
  logic             hit2_c;
  logic             luse_c;
  logic             stall_evt_c;
  logic             take_evt_c;

  hazard_fwd_unit_fwd_sel #(.ASIZE(ASIZE), .ZERO_REG(ZERO_REG)) u_sel_a (
    .use_src  (id_use1),
    .raddr    (id_raddr1),
    .t1_v     (t1.v),
    .t1_wen   (t1.wen),
    .t1_waddr (t1.waddr),
    .t2_v     (t2.v),
    .t2_wen   (t2.wen),
    .t2_waddr (t2.waddr),
    .t3_v     (t3.v),
    .t3_wen   (t3.wen),
    .t3_waddr (t3.waddr),
    .sel_c    (sel_a_c),
    .t1_hit_c (hit1_c),
    .byp_c    (id_byp1)
  );

  hazard_fwd_unit_fwd_sel #(.ASIZE(ASIZE), .ZERO_REG(ZERO_REG)) u_sel_b (
    .use_src  (id_use2),
    .raddr    (id_raddr2),
    .t1_v     (t1.v),
    .t1_wen   (t1.wen),
    .t1_waddr (t1.waddr),
    .t2_v     (t2.v),
    .t2_wen   (t2.wen),
    .t2_waddr (t2.waddr),
    .t3_v     (t3.v),
    .t3_wen   (t3.wen),
    .t3_waddr (t3.waddr),
    .sel_c    (sel_b_c),
    .t1_hit_c (hit2_c),
    .byp_c    (id_byp2)
  );

  // Hazard decisions; a taken branch overrides load-use, a freeze overrides both
  always_comb begin
    luse_c         = id_valid && (hit1_c || hit2_c) && t1.memread;
    take_evt_c     = exe_taken && !ext_stall;
    stall_evt_c    = luse_c && !exe_taken && !ext_stall;
    pc_hold        = ext_stall || stall_evt_c;
    flush_if       = take_evt_c;
    bubble_id      = take_evt_c || stall_evt_c;
    id_tag         = TAG_NONE;
    id_tag.v       = id_valid && !exe_taken && !luse_c;
    id_tag.wen     = id_wen;
    id_tag.waddr   = id_waddr;
    id_tag.memread = id_memread;
  end

  // Advance scoreboard, forward selects and event counters unless frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t1        <= TAG_NONE;
      t2        <= WTAG_NONE;
      t3        <= WTAG_NONE;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!ext_stall) begin
      t3       <= t2;
      t2.v     <= t1.v;
      t2.wen   <= t1.wen;
      t2.waddr <= t1.waddr;
      t1       <= id_tag;
      fwd_a    <= id_tag.v ? sel_a_c : FWD_RF;
      fwd_b    <= id_tag.v ? sel_b_c : FWD_RF;
      if (stall_evt_c && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (take_evt_c && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios plus randomized traffic against a stage-list model.
module tb_hazard_fwd_unit;

  localparam int unsigned AW   = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          ext_stall, id_valid, id_use1, id_use2, id_wen, id_memread, exe_taken;
  logic [AW-1:0] id_raddr1, id_raddr2, id_waddr;
  logic          pc_hold, flush_if, bubble_id, id_byp1, id_byp2;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.ASIZE(AW), .ZERO_REG(1), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_stall  (ext_stall),
    .id_valid   (id_valid),
    .id_raddr1  (id_raddr1),
    .id_raddr2  (id_raddr2),
    .id_use1    (id_use1),
    .id_use2    (id_use2),
    .id_wen     (id_wen),
    .id_waddr   (id_waddr),
    .id_memread (id_memread),
    .exe_taken  (exe_taken),
    .pc_hold    (pc_hold),
    .flush_if   (flush_if),
    .bubble_id  (bubble_id),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .id_byp1    (id_byp1),
    .id_byp2    (id_byp2),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // ---------------- reference model: list of in-flight instructions ----------------
  // stage 1 = EXE (ID_EXE reg), 2 = DM, 3 = WB
  bit mv[1:3];
  bit mw[1:3];
  int ma[1:3];
  bit mm[1:3];
  int efa, efb, esc, efc;

  task automatic model_reset();
    for (int s = 1; s <= 3; s++) begin
      mv[s] = 0; mw[s] = 0; ma[s] = 0; mm[s] = 0;
    end
    efa = 0; efb = 0; esc = 0; efc = 0;
  endtask

  function automatic bit hit(int s, int r);
    return mv[s] && mw[s] && (ma[s] == r) && (r != 0);
  endfunction

  // nearest older producer; its stage number is the forward encoding
  function automatic int pick(bit u, int r);
    if (!u) return 0;
    for (int s = 1; s <= 2; s++) if (hit(s, r)) return s;
    return 0;
  endfunction

  function automatic bit m_luse();
    return id_valid && mm[1] &&
           ((id_use1 && hit(1, int'(id_raddr1))) || (id_use2 && hit(1, int'(id_raddr2))));
  endfunction

  function automatic bit m_stall();
    return !ext_stall && !exe_taken && m_luse();
  endfunction

  function automatic bit m_bubble();
    return !ext_stall && (exe_taken || m_luse());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each clock edge
  always @(posedge clk) begin
    if (rst === 1'b1 && ext_stall === 1'b0) begin
      bit ins;
      int na, nb;
      ins = id_valid && !m_bubble();
      na  = ins ? pick(id_use1, int'(id_raddr1)) : 0;
      nb  = ins ? pick(id_use2, int'(id_raddr2)) : 0;
      if (m_stall() && esc < CMAX) esc++;
      if (exe_taken && efc < CMAX) efc++;
      for (int s = 3; s >= 2; s--) begin
        mv[s] = mv[s-1]; mw[s] = mw[s-1]; ma[s] = ma[s-1]; mm[s] = mm[s-1];
      end
      mv[1] = ins; mw[1] = id_wen; ma[1] = int'(id_waddr); mm[1] = id_memread;
      efa = na; efb = nb;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("pc_hold",   pc_hold,   ext_stall || m_stall());
      chk("flush_if",  flush_if,  !ext_stall && exe_taken);
      chk("bubble_id", bubble_id, m_bubble());
      chk("id_byp1",   id_byp1,   id_use1 && hit(3, int'(id_raddr1)));
      chk("id_byp2",   id_byp2,   id_use2 && hit(3, int'(id_raddr2)));
      chk("fwd_a",     fwd_a,     efa);
      chk("fwd_b",     fwd_b,     efb);
      chk("stall_cnt", stall_cnt, esc);
      chk("flush_cnt", flush_cnt, efc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic instr(bit v, int r1, int r2, bit u1, bit u2, bit w, int wa, bit mr);
    id_valid   = v;
    id_raddr1  = AW'(r1);
    id_raddr2  = AW'(r2);
    id_use1    = u1;
    id_use2    = u2;
    id_wen     = w;
    id_waddr   = AW'(wa);
    id_memread = mr;
  endtask

  task automatic nop();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    repeat (3) adv();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc_hold"},   pc_hold,   0);
    chk({tag, "_flush_if"},  flush_if,  0);
    chk({tag, "_bubble_id"}, bubble_id, 0);
    chk({tag, "_fwd_a"},     fwd_a,     0);
    chk({tag, "_fwd_b"},     fwd_b,     0);
    chk({tag, "_byp1"},      id_byp1,   0);
    chk({tag, "_byp2"},      id_byp2,   0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_flush_cnt"}, flush_cnt, 0);
  endtask

  bit hold;

  initial begin
    rst = 1'b0;
    ext_stall = 1'b0;
    exe_taken = 1'b0;
    nop();
    model_reset();
    #12;
    chk_all_zero("reset");
    rst = 1'b1;
    adv();

    // ADD r3 ; ADD r4=r3+r1 back-to-back
    instr(1, 1, 2, 1, 1, 1, 3, 0); adv();
    instr(1, 3, 1, 1, 1, 1, 4, 0); settle(); chk("A_pc_hold", pc_hold, 0); adv();
    nop(); settle();
    chk("A_fwd_a", fwd_a, 1); chk("A_fwd_b", fwd_b, 0); chk("A_stall_cnt", stall_cnt, 0);
    drain();

    // ADD r3 ; NOP ; SUB r5=r1-r3
    instr(1, 1, 2, 1, 1, 1, 3, 0); adv();
    nop(); adv();
    instr(1, 1, 3, 1, 1, 1, 5, 0); adv();
    nop(); settle(); chk("B1_fwd_b", fwd_b, 2); chk("B1_fwd_a", fwd_a, 0);
    drain();

    // ADD r3 ; NOP ; NOP ; SUB r5=r1-r3
    instr(1, 1, 2, 1, 1, 1, 3, 0); adv();
    nop(); adv(); adv();
    instr(1, 1, 3, 1, 1, 1, 5, 0); settle();
    chk("B2_byp2", id_byp2, 1); chk("B2_byp1", id_byp1, 0); adv();
    nop(); settle(); chk("B2_fwd_b", fwd_b, 0);
    drain();

    // LW r2 ; ADD r6=r2+r2
    instr(1, 0, 0, 0, 0, 1, 2, 1); adv();
    instr(1, 2, 2, 1, 1, 1, 6, 0); settle();
    chk("C_pc_hold", pc_hold, 1); chk("C_bubble", bubble_id, 1); chk("C_flush", flush_if, 0); adv();
    settle(); chk("C_pc_hold2", pc_hold, 0); chk("C_bubble2", bubble_id, 0); adv();
    nop(); settle();
    chk("C_fwd_a", fwd_a, 2); chk("C_fwd_b", fwd_b, 2); chk("C_stall_cnt", stall_cnt, 1);
    drain();

    // LW r2 ; load-use consumer with taken branch in EXE
    instr(1, 0, 0, 0, 0, 1, 2, 1); adv();
    instr(1, 2, 1, 1, 1, 1, 6, 0); exe_taken = 1'b1; settle();
    chk("D_flush", flush_if, 1); chk("D_bubble", bubble_id, 1); chk("D_pc_hold", pc_hold, 0); adv();
    exe_taken = 1'b0; nop(); settle();
    chk("D_stall_cnt", stall_cnt, 1); chk("D_flush_cnt", flush_cnt, 1); chk("D_fwd_a", fwd_a, 0);
    drain();

    // writer of r0 ; reader of r0
    instr(1, 1, 2, 1, 1, 1, 0, 1); adv();
    instr(1, 0, 0, 1, 1, 1, 7, 0); settle();
    chk("E_byp1", id_byp1, 0); chk("E_pc_hold", pc_hold, 0); adv();
    nop(); settle(); chk("E_fwd_a", fwd_a, 0); chk("E_fwd_b", fwd_b, 0);
    // ADD r3 ; reader of r3 frozen for three cycles (branch ignored meanwhile)
    instr(1, 1, 2, 1, 1, 1, 3, 0); adv();
    instr(1, 3, 0, 1, 0, 1, 8, 0); ext_stall = 1'b1; exe_taken = 1'b1;
    repeat (3) begin
      settle(); chk("E_frz_pc_hold", pc_hold, 1); chk("E_frz_flush", flush_if, 0);
      chk("E_frz_bubble", bubble_id, 0); adv();
    end
    ext_stall = 1'b0; exe_taken = 1'b0; settle(); chk("E_rel_pc_hold", pc_hold, 0); adv();
    nop(); settle(); chk("E_rel_fwd_a", fwd_a, 1); chk("E_rel_flush_cnt", flush_cnt, 1);
    drain();

    // 21 load-use stalls saturate a 4-bit counter
    repeat (21) begin
      instr(1, 0, 0, 0, 0, 1, 2, 1); adv();
      instr(1, 2, 2, 1, 1, 1, 6, 0); adv(); adv();
    end
    nop(); settle(); chk("F_stall_sat", stall_cnt, 15);
    drain();

    // Reset asserted during a load-use stall
    instr(1, 0, 0, 0, 0, 1, 2, 1); adv();
    instr(1, 2, 2, 1, 1, 1, 6, 0); settle(); chk("G_pc_hold", pc_hold, 1);
    #1 rst = 1'b0;
    model_reset();
    #1 chk_all_zero("G_rst");
    #1 rst = 1'b1;
    #1 chk("G_rel_pc_hold", pc_hold, 0); chk("G_rel_bubble", bubble_id, 0);
    adv();
    drain();

    // Randomized traffic; ID holds its instruction while the PC is held
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        bit w;
        w = ($urandom % 2) == 1;
        instr(($urandom % 5) != 0, int'($urandom % 4), int'($urandom % 4),
              ($urandom % 4) != 0, ($urandom % 2) == 1, w, int'($urandom % 4),
              w && (($urandom % 3) == 0));
      end
      exe_taken = ($urandom % 8) == 0;
      ext_stall = ($urandom % 8) == 0;
      settle();
      hold = ext_stall || m_stall();
      adv();
    end
    ext_stall = 1'b0;
    exe_taken = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
